buffer_writer: RTL and testbench

Producer-side companion to the 4-slot byte buffer. Accepts a byte stream over a valid/ready handshake and assembles four consecutive bytes into a frame on four parallel 8-bit outputs (slot 0 = first byte). Once the frame is complete it holds the outputs stable and asserts `frame_valid` until the consumer acknowledges. It then re-opens for the next frame. It sits upstream of the buffer, driving its four `data_in_*` lanes.

---
 rtl/buffer_writer_if.sv | 29 ++
 rtl/buffer_writer.sv | 90 +++++++++
 tb/tb_buffer_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/buffer_writer_if.sv
// rtl/buffer_writer_if.sv - byte-stream in, four-slot frame out, for buffer_writer
interface buffer_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  frame_ack;
  logic                  flush;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic [DATA_WIDTH-1:0] data_out_2;
  logic [DATA_WIDTH-1:0] data_out_3;
  logic                  frame_valid;
  logic [2:0]            fill_level;
  logic [7:0]            frame_count;

  modport master (
    output wr_valid, wr_data, frame_ack, flush,
    input  wr_ready, data_out_0, data_out_1, data_out_2, data_out_3,
    input  frame_valid, fill_level, frame_count
  );

  modport slave (
    input  wr_valid, wr_data, frame_ack, flush,
    output wr_ready, data_out_0, data_out_1, data_out_2, data_out_3,
    output frame_valid, fill_level, frame_count
  );
endinterface

// File: rtl/buffer_writer.sv
// rtl/buffer_writer.sv - assembles four streamed bytes into a held frame until acknowledged
module buffer_writer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  buffer_writer_if.slave   bus
);
  typedef enum logic {FILL, FULL} state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            idx;
  logic [1:0]            idx_next;
  logic                  ready;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] slot [4];
  logic                  frame_valid;
  logic [2:0]            fill_level;
  logic [7:0]            frame_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // flush dominates both a transfer and an ack
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (bus.flush) begin
      state_next = FILL;
      idx_next   = 2'd0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            idx_next = idx + 2'd1;
            if (idx == 2'd3) state_next = FULL;
          end
        end
        FULL: begin
          if (bus.frame_ack) state_next = FILL;
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_comb begin
    ready = (state == FILL) && !bus.flush && !rst;
    xfer  = bus.wr_valid && ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      frame_valid <= 1'b0;
      fill_level  <= 3'd0;
      frame_count <= 8'd0;
    end else begin
      if (xfer) slot[idx] <= bus.wr_data;
      if (bus.flush) begin
        frame_valid <= 1'b0;
        fill_level  <= 3'd0;
      end else if (xfer) begin
        fill_level <= fill_level + 3'd1;
        if (idx == 2'd3) frame_valid <= 1'b1;
      end else if (state == FULL && bus.frame_ack) begin
        frame_valid <= 1'b0;
        fill_level  <= 3'd0;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign bus.wr_ready    = ready;
  assign bus.data_out_0  = slot[0];
  assign bus.data_out_1  = slot[1];
  assign bus.data_out_2  = slot[2];
  assign bus.data_out_3  = slot[3];
  assign bus.frame_valid = frame_valid;
  assign bus.fill_level  = fill_level;
  assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_buffer_writer.sv
// tb/tb_buffer_writer.sv - scoreboard bench for buffer_writer
module tb_buffer_writer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  cnt;
  } frame_t;

  frame_t exp_q[$];
  logic   prev_fv = 1'b0;

  buffer_writer_if bus ();

  buffer_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slots();
    return {bus.data_out_0, bus.data_out_1, bus.data_out_2, bus.data_out_3};
  endfunction

  // Each newly presented frame is matched against the oldest expected frame
  always @(negedge clk) begin
    if (bus.frame_valid && !prev_fv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", slots(), 64'hx);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("frame_data", slots(), f.data);
        chk("frame_count_at_present", bus.frame_count, f.cnt);
        chk("frame_fill", bus.fill_level, 3'd4);
      end
    end
    prev_fv = bus.frame_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    bus.frame_ack = 1'b0;
    bus.flush     = 1'b0;

    tick();
    chk("ready_in_reset", bus.wr_ready, 1'b0);
    tick();
    chk("ready_in_reset2", bus.wr_ready, 1'b0);
    chk("reset_slots", slots(), 32'h0);
    chk("reset_fv", bus.frame_valid, 1'b0);
    chk("reset_fill", bus.fill_level, 3'd0);
    chk("reset_count", bus.frame_count, 8'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", bus.wr_ready, 1'b1);

    // back-to-back fill
    exp_q.push_back('{data: 32'h11223344, cnt: 8'd0});
    bus.wr_valid = 1'b1;
    bus.wr_data = 8'h11; tick();
    chk("fill_lvl1", bus.fill_level, 3'd1);
    bus.wr_data = 8'h22; tick();
    bus.wr_data = 8'h33; tick();
    bus.wr_data = 8'h44; tick();
    chk("fv_after_44", bus.frame_valid, 1'b1);
    bus.wr_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_full", {slots(), bus.frame_valid, bus.wr_ready, bus.fill_level},
          {32'h11223344, 1'b1, 1'b0, 3'd4});
      tick();
    end
    bus.wr_valid = 1'b0;

    ack();
    chk("ack_count", bus.frame_count, 8'd1);
    chk("ack_fv", bus.frame_valid, 1'b0);
    chk("ack_ready", bus.wr_ready, 1'b1);
    send(8'hAA);
    chk("refill_slots", slots(), 32'hAA223344);
    chk("refill_fill", bus.fill_level, 3'd1);

    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("flush_partial_fill", bus.fill_level, 3'd0);

    // gapped input
    exp_q.push_back('{data: 32'h01020304, cnt: 8'd1});
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1));
      if (i < 3) chk("gap_fv_early", bus.frame_valid, 1'b0);
      bus.wr_data = 8'hEE;
      if (i < 3) begin
        tick();
        chk("gap_fv_idle", bus.frame_valid, 1'b0);
      end
    end
    chk("gap_fv_done", bus.frame_valid, 1'b1);
    ack();
    chk("gap_ack_count", bus.frame_count, 8'd2);

    // flush mid-frame with a competing byte
    send(8'h5A);
    send(8'h5B);
    bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h77;
    #1;
    chk("flush_ready", bus.wr_ready, 1'b0);
    tick();
    bus.flush = 1'b0; bus.wr_valid = 1'b0;
    chk("flush_mid_fill", bus.fill_level, 3'd0);
    chk("flush_mid_slots", slots(), 32'h5A5B0304);

    exp_q.push_back('{data: 32'hC1C2C3C4, cnt: 8'd2});
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    bus.flush = 1'b1; bus.frame_ack = 1'b1;
    tick();
    bus.flush = 1'b0; bus.frame_ack = 1'b0;
    chk("flush_ack_count", bus.frame_count, 8'd2);
    chk("flush_ack_fv", bus.frame_valid, 1'b0);
    chk("flush_ack_fill", bus.fill_level, 3'd0);

    // counter wrap from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rereset_count", bus.frame_count, 8'd0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = 8'(k);
      exp_q.push_back('{data: {b, ~b, b ^ 8'h5A, b + 8'd1}, cnt: b});
      send(b); send(~b); send(b ^ 8'h5A); send(b + 8'd1);
      ack();
      if (k == 254) chk("count_255", bus.frame_count, 8'hFF);
      if (k == 255) chk("count_wrap", bus.frame_count, 8'h00);
    end

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
